pll_lock_reset_ctrl: RTL and testbench
======================================

Name: pll_lock_reset_ctrl

Overview:
- Companion controller for the fixed-ratio PLL wrapper (50 MHz refclk to 150 MHz outclk).
- Drives the PLL's active-high rst and consumes its locked output.
- Qualifies lock with synchronisation, a stability window and glitch filtering.
- Issues a clean system reset to downstream logic, such as the danmaku feeder, and re-initialises the PLL automatically on lock loss or lock timeout.
- Runs entirely in the refclk domain. Downstream blocks re-synchronise sys_rst_n into outclk themselves.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (>=2).
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before release (>=2).
- TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before a retry (> STABLE_CYCLES).
- GLITCH_CYCLES, 4: consecutive unlocked cycles in RUN treated as real lock loss (>=1).
- CNT_W, 17: width of the internal counters (must hold TIMEOUT_CYCLES-1).

Ports:
- clk, input, 1: reference clock, 50 MHz, same net as the PLL refclk.
- rst_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL locked output; asynchronous to clk, synchronised internally.
- force_reset, input, 1: single-cycle request to re-initialise the PLL.
- clear_err, input, 1: clears timeout_err and relock_cnt.
- pll_rst, output, 1: active-high reset to the PLL.
- sys_rst_n, output, 1: active-low system reset; deasserts synchronously to clk.
- ready, output, 1: PLL locked and qualified; system out of reset.
- timeout_err, output, 1: sticky; set on any WAIT_LOCK timeout.
- relock_cnt, output, 8: saturating count of lock-loss events detected in RUN.
- state_o, output, 2: current state, for debug. RESET_PLL=0, WAIT_LOCK=1, RUN=2.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - pll_rst=1, sys_rst_n=0, ready=0, timeout_err=0, relock_cnt=0.
  - State is RESET_PLL; all counters are 0; synchroniser flops are 0.
- All outputs are registered.
- pll_locked passes through a 2-FF synchroniser to give locked_s. This adds 2 cycles of latency.
- RESET_PLL:
  - pll_rst=1, sys_rst_n=0, ready=0.
  - The counter runs 0..RST_CYCLES-1. At count RST_CYCLES-1 the FSM moves to WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_CYCLES cycles, counted from the first clk edge after rst_n deasserts.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - stable_cnt increments while locked_s=1 and clears to 0 when locked_s=0.
  - When locked_s=1 and stable_cnt=STABLE_CYCLES-1, go to RUN.
  - The timeout counter increments every cycle in WAIT_LOCK. At TIMEOUT_CYCLES-1, if the RUN condition is not met that cycle, set timeout_err and go to RESET_PLL.
  - If RUN and timeout qualify in the same cycle, RUN wins.
- RUN:
  - sys_rst_n=1 and ready=1, both from the first cycle in RUN.
  - glitch_cnt counts consecutive locked_s=0 cycles and clears on locked_s=1.
  - When glitch_cnt reaches GLITCH_CYCLES, go to RESET_PLL. On that same edge: sys_rst_n=0, ready=0, and relock_cnt increments (saturating at 255).
  - Unlocked runs shorter than GLITCH_CYCLES have no effect.
- Every entry to a state clears the counters.
- force_reset=1 in any state has the highest priority:
  - Next state is RESET_PLL with sys_rst_n=0, ready=0, pll_rst=1 on the next edge.
  - relock_cnt is not incremented.
  - force_reset asserted during RESET_PLL restarts the RST_CYCLES count.
- clear_err=1 zeroes timeout_err and relock_cnt on the next edge. Clear wins over a simultaneous set or increment.
- An rst_n assertion mid-operation immediately returns all outputs to their reset values, asynchronously.
- Total release latency from reset with the PLL already locked: RST_CYCLES + STABLE_CYCLES cycles. This holds while the synchroniser shows locked within the window.

Test Plan (sim params: RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, GLITCH_CYCLES=3):
- Release rst_n; assert pll_locked 2 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n and ready rise 2+8 cycles after locked; relock_cnt=0.
- pll_locked stays 0 -> timeout_err=1 after 32 WAIT_LOCK cycles; pll_rst re-asserts for 4 cycles; this repeats every 36 cycles; sys_rst_n stays 0.
- In RUN, drop pll_locked for 2 cycles -> no change. Drop it for 3+ cycles -> sys_rst_n=0, ready=0, relock_cnt=1, pll_rst=1 on the next edge.
- In WAIT_LOCK, toggle pll_locked high 5 cycles, low 1, then high -> stable_cnt restarts; RUN is entered only after 8 consecutive synchronised-high cycles.
- Force 300 lock losses -> relock_cnt saturates at 255. Pulse clear_err together with a loss event -> relock_cnt=0 and timeout_err=0.
- Pulse force_reset in RUN -> pll_rst=1, sys_rst_n=0 next edge, relock_cnt unchanged. Assert rst_n=0 mid-WAIT_LOCK -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/pll_lock_reset_ctrl.sv
// pll_lock_reset_ctrl: sequences PLL reset, qualifies lock and issues system reset
module pll_lock_reset_ctrl #(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int GLITCH_CYCLES  = 4,
   parameter int CNT_W          = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       force_reset,
   input  logic       clear_err,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       timeout_err,
   output logic [7:0] relock_cnt,
   output logic [1:0] state_o
);
   typedef enum logic [1:0] {RESET_PLL = 2'd0, WAIT_LOCK = 2'd1, RUN = 2'd2} state_t;
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, aux, aux_nx;
   logic             sync_q, locked_s, to_hit, loss;
   // cnt: reset length in RESET_PLL, timeout in WAIT_LOCK; aux: stable run or glitch run
   always_comb begin
      state_nx = state;
      cnt_nx   = (state == RUN) ? cnt : cnt + 1'b1;
      aux_nx   = '0;
      to_hit   = 1'b0;
      loss     = 1'b0;
      case (state)
         RESET_PLL: state_nx = (cnt == RST_LAST) ? WAIT_LOCK : RESET_PLL;
         WAIT_LOCK: begin
            aux_nx = locked_s ? aux + 1'b1 : '0;
            if (locked_s && aux == STABLE_LAST) state_nx = RUN;
            else if (cnt == TO_LAST) begin
               state_nx = RESET_PLL;
               to_hit   = 1'b1;
            end
         end
         RUN: begin
            aux_nx = locked_s ? '0 : aux + 1'b1;
            if (!locked_s && aux == GLITCH_LAST) begin
               state_nx = RESET_PLL;
               loss     = 1'b1;
            end
         end
         default: state_nx = RESET_PLL;
      endcase
      if (force_reset) begin
         state_nx = RESET_PLL;
         to_hit   = 1'b0;
         loss     = 1'b0;
      end
      if (force_reset || state_nx != state) begin
         cnt_nx = '0;
         aux_nx = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 1'b0;
         locked_s    <= 1'b0;
         state       <= RESET_PLL;
         cnt         <= '0;
         aux         <= '0;
         pll_rst     <= 1'b1;
         sys_rst_n   <= 1'b0;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
         relock_cnt  <= '0;
      end else begin
         sync_q      <= pll_locked;
         locked_s    <= sync_q;
         state       <= state_nx;
         cnt         <= cnt_nx;
         aux         <= aux_nx;
         pll_rst     <= state_nx == RESET_PLL;
         sys_rst_n   <= state_nx == RUN;
         ready       <= state_nx == RUN;
         timeout_err <= clear_err ? 1'b0 : (timeout_err | to_hit);
         relock_cnt  <= clear_err ? 8'd0 : relock_cnt + 8'(loss && relock_cnt != 8'hff);
      end
   end
   assign state_o = state;
endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb_pll_lock_reset_ctrl: directed vectors for pll_lock_reset_ctrl with small timing params
module tb_pll_lock_reset_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, force_reset = 1'b0, clear_err = 1'b0;
   logic       pll_rst, sys_rst_n, ready, timeout_err;
   logic [7:0] relock_cnt;
   logic [1:0] state_o;
   int         vectors = 0, miscompares = 0;

   pll_lock_reset_ctrl #(.RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32),
                         .GLITCH_CYCLES(3), .CNT_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .force_reset(force_reset),
      .clear_err(clear_err), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
      .timeout_err(timeout_err), .relock_cnt(relock_cnt), .state_o(state_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic relock();
      pll_locked = 1'b1;
      for (int i = 0; i < 40 && !ready; i++) tick(1);
      chk("relock_ready", int'(ready), 1);
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_relock_cnt", int'(relock_cnt), 0);
      chk("rst_state", int'(state_o), 0);
      rst_n = 1'b1;
      // pll_rst spans four edges after release
      tick(3);
      chk("boot_pll_rst_e3", int'(pll_rst), 1);
      tick(1);
      chk("boot_pll_rst_e4", int'(pll_rst), 0);
      chk("boot_state_wait", int'(state_o), 1);
      tick(2);
      pll_locked = 1'b1;
      tick(9);
      chk("boot_ready_early", int'(ready), 0);
      chk("boot_sys_early", int'(sys_rst_n), 0);
      tick(1);
      chk("boot_ready", int'(ready), 1);
      chk("boot_sys_rst_n", int'(sys_rst_n), 1);
      chk("boot_state_run", int'(state_o), 2);
      chk("boot_relock_cnt", int'(relock_cnt), 0);
      // two-cycle dropout is filtered
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      tick(6);
      chk("glitch2_ready", int'(ready), 1);
      chk("glitch2_state", int'(state_o), 2);
      // three-cycle dropout is a real loss
      pll_locked = 1'b0;
      tick(4);
      chk("glitch3_ready_pre", int'(ready), 1);
      tick(1);
      chk("loss_sys_rst_n", int'(sys_rst_n), 0);
      chk("loss_ready", int'(ready), 0);
      chk("loss_relock_cnt", int'(relock_cnt), 1);
      chk("loss_pll_rst", int'(pll_rst), 1);
      chk("loss_state", int'(state_o), 0);
      // no lock: timeout every 36 cycles
      tick(35);
      chk("to_err_pre", int'(timeout_err), 0);
      chk("to_state_pre", int'(state_o), 1);
      tick(1);
      chk("to_err", int'(timeout_err), 1);
      chk("to_pll_rst", int'(pll_rst), 1);
      chk("to_sys_rst_n", int'(sys_rst_n), 0);
      tick(3);
      chk("to_pll_rst_hold", int'(pll_rst), 1);
      tick(1);
      chk("to_pll_rst_fall", int'(pll_rst), 0);
      tick(31);
      chk("to2_pll_rst_pre", int'(pll_rst), 0);
      tick(1);
      chk("to2_pll_rst", int'(pll_rst), 1);
      chk("to2_sys_rst_n", int'(sys_rst_n), 0);
      // lock toggles in WAIT_LOCK restart the stability window
      tick(4);
      chk("tog_state_wait", int'(state_o), 1);
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(4);
      chk("tog_ready_e10", int'(ready), 0);
      tick(5);
      chk("tog_ready_e15", int'(ready), 0);
      chk("tog_state_e15", int'(state_o), 1);
      tick(1);
      chk("tog_ready_e16", int'(ready), 1);
      chk("tog_timeout_sticky", int'(timeout_err), 1);
      // force_reset in RUN, then again mid RESET_PLL
      tick(2);
      force_reset = 1'b1;
      tick(1);
      force_reset = 1'b0;
      chk("force_pll_rst", int'(pll_rst), 1);
      chk("force_sys_rst_n", int'(sys_rst_n), 0);
      chk("force_ready", int'(ready), 0);
      chk("force_relock_cnt", int'(relock_cnt), 1);
      tick(2);
      force_reset = 1'b1;
      tick(1);
      force_reset = 1'b0;
      tick(3);
      chk("force_restart_state", int'(state_o), 0);
      chk("force_restart_pll_rst", int'(pll_rst), 1);
      tick(1);
      chk("force_restart_wait", int'(state_o), 1);
      tick(7);
      chk("force_ready_early", int'(ready), 0);
      tick(1);
      chk("force_ready", int'(ready), 1);
      // saturate relock_cnt
      for (int i = 0; i < 253; i++) begin
         pll_locked = 1'b0;
         tick(5);
         relock();
      end
      chk("sat_254", int'(relock_cnt), 254);
      pll_locked = 1'b0;
      tick(5);
      relock();
      chk("sat_255", int'(relock_cnt), 255);
      for (int i = 0; i < 46; i++) begin
         pll_locked = 1'b0;
         tick(5);
         relock();
      end
      chk("sat_hold", int'(relock_cnt), 255);
      // clear_err coincident with a loss wins
      pll_locked = 1'b0;
      tick(4);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      chk("clr_relock_cnt", int'(relock_cnt), 0);
      chk("clr_timeout_err", int'(timeout_err), 0);
      chk("clr_state", int'(state_o), 0);
      tick(4);
      chk("mid_state_wait", int'(state_o), 1);
      tick(32);
      chk("mid_timeout_err", int'(timeout_err), 1);
      tick(4);
      chk("mid_state_wait2", int'(state_o), 1);
      // asynchronous reset with no clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pll_rst", int'(pll_rst), 1);
      chk("arst_sys_rst_n", int'(sys_rst_n), 0);
      chk("arst_ready", int'(ready), 0);
      chk("arst_timeout_err", int'(timeout_err), 0);
      chk("arst_relock_cnt", int'(relock_cnt), 0);
      chk("arst_state", int'(state_o), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
